// File: rtl/xillybus_host_emu.sv
`default_nettype none
// ============================================================================
// Module   : xillybus_host_emu
// Brief    : Host-side stand-in for a 32-bit Xillybus stream pair: writes one
//            batch of packed 16-bit lanes, drains the read stream, reports stats.
// Revision : 1.0 - initial release
// ============================================================================
module xillybus_host_emu #(
    parameter int          WORDS       = 256,
    parameter int          OPEN_WAIT   = 4,
    parameter int          TIMEOUT_CYC = 65536,
    parameter logic [15:0] SEED        = 16'h0000
) (
    input  logic        bus_clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [9:0]  rx_count,
    output logic [31:0] rx_sum,
    output logic [31:0] rx_last,
    output logic        w_open,
    output logic        w_wren,
    output logic [31:0] w_data,
    input  logic        w_full,
    output logic        r_open,
    output logic        r_rden,
    input  logic [31:0] r_data,
    input  logic        r_empty,
    input  logic        r_eof
);

    localparam int c_CYC_MAX = (TIMEOUT_CYC > OPEN_WAIT) ? TIMEOUT_CYC : OPEN_WAIT;
    localparam int c_CYC_W   = $clog2(c_CYC_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_OPEN  = 3'd1,
        S_WRITE = 3'd2,
        S_READ  = 3'd3,
        S_DONE  = 3'd4,
        S_TOUT  = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CYC_W-1:0]   r_cyc;
    logic [c_CYC_W-1:0]   w_cyc_inc;
    logic [9:0]           r_wr_k;
    logic [9:0]           r_rd_issued;
    logic                 r_cap;
    logic [9:0]           r_rx_count;
    logic [31:0]          r_rx_sum;
    logic [31:0]          r_rx_last;
    logic                 w_busy;
    logic                 w_idle_like;
    logic                 w_wren_c;
    logic                 w_rden_c;
    logic                 w_cap;
    logic [15:0]          w_lane0;
    logic [15:0]          w_lane1;

    assign w_busy      = (r_state == S_OPEN) || (r_state == S_WRITE) || (r_state == S_READ);
    assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_TOUT);
    assign w_wren_c    = (r_state == S_WRITE) && !w_full;
    assign w_rden_c    = (r_state == S_READ) && !r_empty && (r_rd_issued < 10'(WORDS));
    // A capture landing after the FSM left READ (e.g. on timeout) is discarded
    assign w_cap       = r_cap && (r_state == S_READ);
    assign w_cyc_inc   = r_cyc + 1'b1;
    assign w_lane0     = SEED + {5'd0, r_wr_k, 1'b0};
    assign w_lane1     = w_lane0 + 16'd1;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_TOUT: begin
                if (start) w_state_nxt = S_OPEN;
            end
            S_OPEN: begin
                if (w_cyc_inc == c_CYC_W'(OPEN_WAIT)) w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                if (w_wren_c && (r_wr_k == 10'(WORDS - 1)))
                    w_state_nxt = S_READ;
                else if (!w_wren_c && (w_cyc_inc == c_CYC_W'(TIMEOUT_CYC)))
                    w_state_nxt = S_TOUT;
            end
            S_READ: begin
                // eof on an empty stream ends a short batch; pending capture still lands
                if (w_cap && (r_rx_count == 10'(WORDS - 1)))
                    w_state_nxt = S_DONE;
                else if (r_eof && r_empty)
                    w_state_nxt = S_DONE;
                else if (!w_cap && (w_cyc_inc == c_CYC_W'(TIMEOUT_CYC)))
                    w_state_nxt = S_TOUT;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge bus_clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cyc       <= '0;
            r_wr_k      <= '0;
            r_rd_issued <= '0;
            r_cap       <= 1'b0;
            r_rx_count  <= '0;
            r_rx_sum    <= '0;
            r_rx_last   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cap   <= w_rden_c;
            if ((w_state_nxt != r_state) || w_wren_c || w_cap || !w_busy)
                r_cyc <= '0;
            else
                r_cyc <= w_cyc_inc;

            if (w_idle_like && start) begin
                r_wr_k      <= '0;
                r_rd_issued <= '0;
                r_rx_count  <= '0;
                r_rx_sum    <= '0;
                r_rx_last   <= '0;
            end else begin
                if (w_wren_c) r_wr_k <= r_wr_k + 10'd1;
                if (w_rden_c) r_rd_issued <= r_rd_issued + 10'd1;
                if (w_cap) begin
                    r_rx_count <= r_rx_count + 10'd1;
                    r_rx_sum   <= r_rx_sum + r_data;
                    r_rx_last  <= r_data;
                end
            end
        end
    end

    assign busy     = w_busy;
    assign done     = (r_state == S_DONE);
    assign timeout  = (r_state == S_TOUT);
    assign w_open   = w_busy;
    assign r_open   = w_busy;
    assign w_wren   = w_wren_c;
    assign r_rden   = w_rden_c;
    assign w_data   = (r_state == S_WRITE) ? {w_lane1, w_lane0} : 32'd0;
    assign rx_count = r_rx_count;
    assign rx_sum   = r_rx_sum;
    assign rx_last  = r_rx_last;

endmodule
`default_nettype wire

// File: tb/tb_xillybus_host_emu.sv
`default_nettype none
// ============================================================================
// Module   : tb_xillybus_host_emu
// Brief    : Directed bench with a loopback FIFO peer and a write-word scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xillybus_host_emu;

    localparam int          WORDS       = 256;
    localparam int          OPEN_WAIT   = 4;
    localparam int          TIMEOUT_CYC = 100;
    localparam logic [15:0] SEED        = 16'h0000;

    logic        bus_clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, timeout;
    logic [9:0]  rx_count;
    logic [31:0] rx_sum, rx_last;
    logic        w_open, w_wren, r_open, r_rden;
    logic [31:0] w_data;
    logic        w_full, r_empty, r_eof;
    logic [31:0] r_data = 32'd0;

    logic        force_full = 1'b0;
    logic        force_empty = 1'b0;
    logic        eof_en = 1'b0;
    int          rd_limit = 1024;

    logic [31:0] mem [0:1023];
    int          wp = 0, rp = 0, rd_cnt = 0, viol = 0, cyc = 0, last_acc = 0;

    int          checks = 0, errors = 0, chk_idx = 0;
    logic [31:0] exp_q [$];

    always #5 bus_clk = ~bus_clk;

    xillybus_host_emu #(
        .WORDS(WORDS), .OPEN_WAIT(OPEN_WAIT), .TIMEOUT_CYC(TIMEOUT_CYC), .SEED(SEED)
    ) dut (
        .bus_clk(bus_clk), .rst(rst), .start(start),
        .busy(busy), .done(done), .timeout(timeout),
        .rx_count(rx_count), .rx_sum(rx_sum), .rx_last(rx_last),
        .w_open(w_open), .w_wren(w_wren), .w_data(w_data), .w_full(w_full),
        .r_open(r_open), .r_rden(r_rden), .r_data(r_data),
        .r_empty(r_empty), .r_eof(r_eof)
    );

    assign w_full  = force_full;
    assign r_empty = force_empty || (wp == rp) || (rd_cnt >= rd_limit);
    assign r_eof   = eof_en && r_empty;

    // Loopback peer: FIFO contents are flushed whenever both device files are closed
    always @(posedge bus_clk) begin
        cyc  <= cyc + 1;
        viol <= viol + int'(w_wren && w_full) + int'(r_rden && r_empty) + int'(w_wren && r_rden);
        if (!w_open && !r_open) begin
            wp     <= 0;
            rp     <= 0;
            rd_cnt <= 0;
        end else begin
            if (w_wren) begin
                mem[wp]  <= w_data;
                wp       <= wp + 1;
                last_acc <= cyc;
            end
            if (r_rden) begin
                r_data <= mem[rp];
                rp     <= rp + 1;
                rd_cnt <= rd_cnt + 1;
            end
        end
    end

    function automatic logic [31:0] mword(input int k);
        logic [15:0] lo;
        lo = SEED + 16'(2 * k);
        return {lo + 16'd1, lo};
    endfunction

    function automatic logic [31:0] msum(input int n);
        logic [31:0] s;
        s = 32'd0;
        for (int k = 0; k < n; k++) s = s + mword(k);
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and score every word the peer accepted
    task automatic step();
        @(negedge bus_clk);
        while (chk_idx < wp) begin
            if (exp_q.size() == 0)
                chk("wr_overrun", 32'(chk_idx), 32'(WORDS - 1));
            else
                chk("wdata", mem[chk_idx], exp_q.pop_front());
            chk_idx++;
        end
    endtask

    task automatic begin_batch();
        exp_q.delete();
        for (int k = 0; k < WORDS; k++) exp_q.push_back(mword(k));
        chk_idx = 0;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int budget);
        int n;
        n = 0;
        while (!(done || timeout) && (n < budget)) begin
            step();
            n++;
        end
        chk(tag, 32'(done || timeout), 32'd1);
    endtask

    task automatic wait_wp(input int target, input int budget);
        int n;
        n = 0;
        while ((wp < target) && (n < budget)) begin
            step();
            n++;
        end
        chk("wait_wp", 32'(wp >= target), 32'd1);
    endtask

    task automatic check_results(input string tag, input int n);
        chk({tag, "_done"},    32'(done), 32'd1);
        chk({tag, "_tout"},    32'(timeout), 32'd0);
        chk({tag, "_count"},   32'(rx_count), 32'(n));
        chk({tag, "_sum"},     rx_sum, msum(n));
        chk({tag, "_last"},    rx_last, mword(n - 1));
        chk({tag, "_opens"},   32'({w_open, r_open, busy}), 32'd0);
        chk({tag, "_written"}, 32'(chk_idx), 32'(WORDS));
    endtask

    initial begin
        int n;
        rst = 1'b1;
        repeat (3) @(negedge bus_clk);
        chk("rst_flags", 32'({busy, done, timeout, w_open, r_open, w_wren, r_rden}), 32'd0);
        chk("rst_count", 32'(rx_count), 32'd0);
        chk("rst_sum",   rx_sum, 32'd0);
        chk("rst_last",  rx_last, 32'd0);
        chk("rst_wdata", w_data, 32'd0);
        rst = 1'b0;
        step();

        // rst and start together: rst wins
        rst = 1'b1; start = 1'b1;
        step();
        rst = 1'b0; start = 1'b0;
        step();
        chk("rst_beats_start", 32'({busy, w_open, r_open}), 32'd0);

        // Plain loopback with an ignored start mid-write
        begin_batch();
        chk("open_now", 32'({w_open, r_open, busy}), 32'd7);
        n = 1;
        while (!w_wren && n < 20) begin
            step();
            if (!w_wren) n++;
        end
        chk("open_wait", 32'(n), 32'(OPEN_WAIT));
        wait_wp(100, 400);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_end("t1_end", 3000);
        check_results("t1", WORDS);

        // w_full held high for WRITE cycles 10..40
        begin_batch();
        n = 0;
        while (!w_wren && n < 20) begin step(); n++; end
        n = 0;
        while (!(done || timeout) && n < 3000) begin
            if (n == 10) force_full = 1'b1;
            if (n == 41) force_full = 1'b0;
            #1;
            if (force_full) chk("full_no_wren", 32'(w_wren), 32'd0);
            step();
            n++;
        end
        force_full = 1'b0;
        wait_end("t2_end", 10);
        check_results("t2", WORDS);

        // r_empty toggled every cycle during READ
        begin_batch();
        wait_wp(WORDS, 1000);
        n = 0;
        while (!(done || timeout) && n < 3000) begin
            force_empty = ~force_empty;
            #1;
            if (force_empty) chk("empty_no_rden", 32'(r_rden), 32'd0);
            step();
            n++;
        end
        force_empty = 1'b0;
        wait_end("t3_end", 10);
        check_results("t3", WORDS);

        // Write side stalls after 50 words
        begin_batch();
        wait_wp(50, 400);
        force_full = 1'b1;
        wait_end("t4_end", 400);
        chk("t4_timeout", 32'({timeout, done}), 32'b10);
        chk("t4_opens",   32'({w_open, r_open, busy}), 32'd0);
        chk("t4_latency", 32'(cyc - 1 - last_acc), 32'(TIMEOUT_CYC));
        chk("t4_written", 32'(chk_idx), 32'd50);
        chk("t4_count",   32'(rx_count), 32'd0);
        force_full = 1'b0;
        step();

        // Short batch: eof after 10 words
        rd_limit = 10;
        eof_en   = 1'b1;
        begin_batch();
        wait_end("t5_end", 3000);
        check_results("t5", 10);
        rd_limit = 1024;
        eof_en   = 1'b0;
        step();

        // rst mid-READ, then a clean batch
        begin_batch();
        n = 0;
        while (rx_count < 10'd20 && n < 2000) begin step(); n++; end
        chk("t6_midread", 32'(rx_count >= 10'd20), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_abort_flags", 32'({w_open, r_open, busy, done, timeout}), 32'd0);
        chk("t6_abort_count", 32'(rx_count), 32'd0);
        step();
        step();
        begin_batch();
        wait_end("t6_end", 3000);
        check_results("t6", WORDS);

        chk("protocol", 32'(viol), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
